tt_um_limpix31_r0: RTL and testbench
====================================

TT_UM_LIMPIX31_R0 -- requirements
Module: tt_um_limpix31_r0

Interface
REQ-001 The design SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n as in the codebase.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design-selected flag; SHALL be ignored by the logic.
REQ-005 ui_in  input  8  write data byte.
REQ-006 uio_in  input  8  control inputs:
- [2:0] register address
- [3] write strobe
- [4] bank select (0 = duty, 1 = config)
- [7:5] unused
REQ-007 uo_out  output  8  registered PWM outputs, bit k = channel k.
REQ-008 uio_out  output  8  status outputs:
- [5] period-start pulse
- [6] write-ack pulse
- [7] PWM counter MSB
- [4:0] constant 0
REQ-009 uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-010 Write strobe SHALL be sampled into a 1-bit register each clock; a write SHALL be accepted in the cycle where uio_in[3]=1 and the previous sample=0 (one write per rising edge of the strobe).
REQ-011 Duty bank (bank=0) write SHALL load ui_in into shadow duty register selected by address[2:0] (8 channels).
REQ-012 Config bank (bank=1) writes:
- addr 0: prescaler P
- addr 1: channel enable mask EN
- addr 2: output invert mask INV
- addr 3-7: ignored
REQ-013 Config registers SHALL take the new value at the clock edge that accepts the write; a write to P SHALL also clear the prescale counter.
REQ-014 Prescaler: an 8-bit prescale counter SHALL count 0..P; a tick SHALL occur when it equals P, and the counter SHALL then return to 0.
- P=0 gives a tick every clock.
- P=255 gives a tick every 256 clocks.
REQ-015 PWM counter CNT (8 bits) SHALL increment by 1 on each tick, wrapping 255->0 (period = 256 ticks).
REQ-016 On the tick where CNT wraps 255->0, all 8 active duty registers SHALL be copied from their shadows; mid-period duty writes SHALL NOT affect the current period.
REQ-017 A shadow write in the same cycle as the copy tick SHALL be included in the copy (the new value is used).
REQ-018 Channel output:
- uo_out[k] SHALL be the registered value of EN[k] & ((CNT < ACT[k]) ^ INV[k]), giving one clock latency from CNT.
- Duty 0 SHALL be never high; duty D SHALL be high for D of 256 ticks.
- A disabled channel SHALL be 0 regardless of INV.
REQ-019 uio_out[5] SHALL be high for exactly one clock, the clock after the wrap tick.
REQ-020 uio_out[6] SHALL be high for exactly one clock after each accepted write to duty addresses 0-7 or config addresses 0-2, and SHALL NOT pulse for ignored addresses.
REQ-021 uio_out[7] SHALL equal CNT[7] (combinational from the register).
REQ-022 Behaviour SHALL be independent of ena and uio_in[7:5].

Reset
REQ-023 While rst_n=0, the following SHALL hold immediately and independently of clk:
- all shadow and active duties = 0
- P = 0
- EN = 8'hFF
- INV = 0
- CNT = 0, prescale counter = 0
- strobe sample = 0
- uo_out = 0
- uio_out = 0
REQ-024 Reset asserted mid-period SHALL abort the period; after release, CNT SHALL restart at 0 on the first tick.

Verification
REQ-025 Reset, then write duty ch0=64 (P=0), run 2 periods -> in the second period uo_out[0] is high exactly 64 of 256 clocks and uio_out[6] pulses once after the write.
REQ-026 Duty ch3=0 and ch4=255 -> uo_out[3] stays 0; uo_out[4] is low exactly 1 clock per 256.
REQ-027 Set P=3 and duty ch1=128 -> period = 1024 clocks, uo_out[1] high 512 clocks, uio_out[5] pulses every 1024 clocks.
REQ-028 Write duty ch2=200 at CNT=100 after ch2=50 was active -> current period shows 50 high ticks, next period shows 200.
REQ-029 EN=8'h0F, INV=8'h03, all duties 0 -> uo_out[1:0]=1, [3:2]=0, [7:4]=0; a write to config addr 5 produces no ack pulse.
REQ-030 Hold uio_in[3]=1 for 10 clocks -> exactly one write accepted and one ack pulse; assert rst_n=0 mid-period -> all outputs 0 immediately.

Source files
------------

// File: rtl/tt_um_limpix31_r0.sv
// 8-channel PWM with double-buffered duty registers and a prescaler.
// Ports: clk, rst_n (async active-low), ena (ignored), ui_in (write data),
//   uio_in (addr[2:0], strobe[3], bank[4]), uo_out (PWM channels),
//   uio_out ([7] CNT MSB, [6] write ack, [5] period start), uio_oe.
module tt_um_limpix31_r0 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [2:0] addr;
    logic       bank;
    logic       strb;
    logic       strb_q;
    logic       wr_acc;
    logic       tick;
    logic       wrap;
    logic       ack_d;
    logic       p_wr;

    logic [7:0] shadow_q [8];
    logic [7:0] shadow_d [8];
    logic [7:0] act_q    [8];
    logic [7:0] p_q;
    logic [7:0] en_q;
    logic [7:0] inv_q;
    logic [7:0] pre_q;
    logic [7:0] cnt_q;
    logic [7:0] out_q;
    logic [7:0] pwm_d;
    logic       start_q;
    logic       ack_q;

    logic       unused_ok;

    assign addr = uio_in[2:0];
    assign strb = uio_in[3];
    assign bank = uio_in[4];

    // One accepted write per rising edge of the strobe.
    assign wr_acc = strb & ~strb_q;
    assign p_wr   = wr_acc & bank & (addr == 3'd0);
    assign ack_d  = wr_acc & (~bank | (addr <= 3'd2));

    assign tick = (pre_q == p_q);
    assign wrap = tick & (cnt_q == 8'hFF);

    assign unused_ok = &{1'b0, ena, uio_in[7:5]};

    // Shadow next-state; also feeds the active copy so a write landing
    // on the wrap tick is picked up by the new period.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_acc && !bank) begin
            shadow_d[addr] = ui_in;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int k = 0; k < 8; k++) begin
            pwm_d[k] = en_q[k] & ((cnt_q < act_q[k]) ^ inv_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= '0;
                act_q[k]    <= '0;
            end
            strb_q  <= 1'b0;
            p_q     <= '0;
            en_q    <= 8'hFF;
            inv_q   <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            strb_q   <= strb;
            shadow_q <= shadow_d;
            if (wrap) begin
                act_q <= shadow_d;
            end
            if (wr_acc && bank) begin
                case (addr)
                    3'd0:    p_q   <= ui_in;
                    3'd1:    en_q  <= ui_in;
                    3'd2:    inv_q <= ui_in;
                    default: ;
                endcase
            end
            if (p_wr || tick) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + 8'd1;
            end
            if (tick) begin
                cnt_q <= cnt_q + 8'd1;
            end
            out_q   <= pwm_d;
            start_q <= wrap;
            ack_q   <= ack_d;
        end
    end

    assign uo_out  = out_q;
    assign uio_out = {cnt_q[7], ack_q, start_q, 5'b0_0000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_limpix31_r0.sv
// Directed bench for tt_um_limpix31_r0.
// Expected values are queued when stimulus is driven and popped on compare.
module tb_tt_um_limpix31_r0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    tt_um_limpix31_r0 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic push(input int e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input int obs);
        int e;
        if (exp_q.size() == 0) e = -999;
        else e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, e);
        end
    endtask

    task automatic wr(input logic b, input logic [2:0] a,
                      input logic [7:0] d, input string tag);
        @(negedge clk);
        ui_in  = d;
        uio_in = {3'b111, b, 1'b1, a};
        push((b == 1'b0 || a <= 3'd2) ? 1 : 0);
        @(negedge clk);
        chk({tag, "_ack"}, int'(uio_out[6]));
        uio_in[3] = 1'b0;
        push(0);
        @(negedge clk);
        chk({tag, "_ack_end"}, int'(uio_out[6]));
    endtask

    task automatic wait_start(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uio_out[5] && n < lim);
        if (!uio_out[5]) n = -1;
    endtask

    task automatic measure(input int len, output int hi [8],
                           output int st, output int stidx);
        for (int k = 0; k < 8; k++) hi[k] = 0;
        st = 0;
        stidx = -1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) hi[k] += int'(uo_out[k]);
            if (uio_out[5]) begin
                st++;
                stidx = i;
            end
        end
    endtask

    initial begin
        int n;
        int hi [8];
        int st;
        int stidx;
        int h2;
        int acks;

        // Reset state
        #12;
        push(0);    chk("rst_uo", int'(uo_out));
        push(0);    chk("rst_uio", int'(uio_out));
        push(8'hE0); chk("rst_oe", int'(uio_oe));
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 = 64 with P = 0
        wr(1'b0, 3'd0, 8'd64, "d0");
        push(1); wait_start(300, n); chk("sync1", int'(n > 0));
        measure(256, hi, st, stidx);
        push(64); chk("ch0_hi", hi[0]);
        push(1);  chk("p1_starts", st);
        push(255); chk("p1_stidx", stidx);

        // ch3 = 0, ch4 = 255
        wr(1'b0, 3'd3, 8'd0, "d3");
        wr(1'b0, 3'd4, 8'd255, "d4");
        push(1); wait_start(600, n); chk("sync2", int'(n > 0));
        measure(256, hi, st, stidx);
        push(0);   chk("ch3_hi", hi[3]);
        push(255); chk("ch4_hi", hi[4]);
        push(64);  chk("ch0_hi2", hi[0]);

        // ch2 = 50 active, rewrite to 200 at CNT = 100
        wr(1'b0, 3'd2, 8'd50, "d2a");
        push(1); wait_start(600, n); chk("sync3", int'(n > 0));
        h2 = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            h2 += int'(uo_out[2]);
            if (i == 99) begin
                ui_in  = 8'd200;
                uio_in = {3'b010, 1'b0, 1'b1, 3'd2};
            end
            if (i == 100) begin
                push(1); chk("mid_ack", int'(uio_out[6]));
                uio_in[3] = 1'b0;
            end
            if (i == 126) begin
                push(0); chk("msb127", int'(uio_out[7]));
            end
            if (i == 127) begin
                push(1); chk("msb128", int'(uio_out[7]));
            end
        end
        push(50); chk("ch2_cur", h2);
        measure(256, hi, st, stidx);
        push(200); chk("ch2_next", hi[2]);

        // P = 3, ch1 = 128
        wr(1'b1, 3'd0, 8'd3, "p3");
        wr(1'b0, 3'd1, 8'd128, "d1");
        push(1); wait_start(2100, n); chk("sync4", int'(n > 0));
        measure(1024, hi, st, stidx);
        push(512);  chk("ch1_hi", hi[1]);
        push(256);  chk("ch0_p3", hi[0]);
        push(1);    chk("p3_starts", st);
        push(1023); chk("p3_stidx", stidx);
        wr(1'b1, 3'd0, 8'd0, "p0");

        // EN / INV masks with all duties 0
        wr(1'b0, 3'd0, 8'd0, "z0");
        wr(1'b0, 3'd1, 8'd0, "z1");
        wr(1'b0, 3'd2, 8'd0, "z2");
        wr(1'b0, 3'd4, 8'd0, "z4");
        wr(1'b1, 3'd1, 8'h0F, "en");
        wr(1'b1, 3'd2, 8'h03, "inv");
        wr(1'b1, 3'd5, 8'h55, "cfg5");
        push(1); wait_start(600, n); chk("sync5", int'(n > 0));
        measure(256, hi, st, stidx);
        push(256); chk("inv_ch0", hi[0]);
        push(256); chk("inv_ch1", hi[1]);
        push(0);   chk("en_ch3", hi[3]);
        push(0);   chk("en_ch7", hi[7]);
        wr(1'b1, 3'd2, 8'hC3, "inv2");
        @(negedge clk);
        push(8'h03); chk("dis_inv", int'(uo_out));

        // Strobe held high for 10 clocks
        acks = 0;
        @(negedge clk);
        ui_in  = 8'd99;
        uio_in = {3'b000, 1'b0, 1'b1, 3'd5};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            acks += int'(uio_out[6]);
        end
        uio_in[3] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            acks += int'(uio_out[6]);
        end
        push(1); chk("hold_acks", acks);

        // Asynchronous reset mid-period
        push(8'h03); chk("pre_rst_uo", int'(uo_out));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        push(0); chk("async_uo", int'(uo_out));
        push(0); chk("async_uio", int'(uio_out));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push(256); wait_start(300, n); chk("restart", n);
        @(negedge clk);
        push(0); chk("post_rst_uo", int'(uo_out));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
